// File: rtl/pipeline_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl_if
// Description : Bundle of the stall/flush sequencer's pipeline-side signals.
//               master : the stall controller (consumes hazard/handshake
//                        inputs, drives stage enables/flushes and timeout)
//               slave  : the pipeline / core top
// Signals     : hz_stall, br_redirect, imem_ack, mem_access, dmem_ack (to ctrl)
//               pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//               if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout (from ctrl)
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_stall_ctrl_if;
    logic hz_stall;
    logic br_redirect;
    logic imem_ack;
    logic mem_access;
    logic dmem_ack;
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
    logic mem_timeout;

    modport master (
        input  hz_stall, br_redirect, imem_ack, mem_access, dmem_ack,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout
    );

    modport slave (
        output hz_stall, br_redirect, imem_ack, mem_access, dmem_ack,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl
// Description : Central stall/flush sequencer for the 5-stage core. Resolves
//               DMEM freeze > redirect > load-use > IMEM wait each cycle,
//               tracks DMEM waits with a watchdog (sticky mem_timeout) and
//               discards the wrong-path fetch in flight after a redirect.
// Ports       : clk, rst (sync, active-high)
//               ctrl           pipeline_stall_ctrl_if.master bundle
//               perf_stall_cyc [31:0] cycles with pc_en=0   (optional)
//               perf_flush_cnt [31:0] redirect events       (optional)
// Config      : define STALL_PERF_CNT_EN to add the performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    pipeline_stall_ctrl_if.master     ctrl
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0]               perf_stall_cyc,
    output logic [31:0]               perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DWAIT = 2'd1,
        S_RPEND = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] C_TIMEOUT = TIMEOUT_W'(TIMEOUT);
    localparam logic [TIMEOUT_W-1:0] C_CNT_MAX = {TIMEOUT_W{1'b1}};

    state_t               r_state;
    logic                 r_pend;        // discard was pending when the freeze began
    logic [TIMEOUT_W-1:0] r_wait_cnt;
    logic                 r_mem_timeout;

    logic w_freeze;
    logic w_eff_rpend;
    logic w_redirect;

    assign w_freeze    = ctrl.mem_access & ~ctrl.dmem_ack;
    // The freeze-exit cycle resumes whatever the freeze interrupted: a pending
    // discard is still honoured so the wrong-path word never reaches IF/ID.
    assign w_eff_rpend = (r_state == S_RPEND) | ((r_state == S_DWAIT) & r_pend);
    assign w_redirect  = ctrl.br_redirect & ~w_freeze;

    always_comb begin
        ctrl.pc_en        = 1'b1;
        ctrl.if_id_en     = 1'b1;
        ctrl.id_ex_en     = 1'b1;
        ctrl.ex_mem_en    = 1'b1;
        ctrl.mem_wb_en    = 1'b1;
        ctrl.if_id_flush  = 1'b0;
        ctrl.id_ex_flush  = 1'b0;
        ctrl.mem_wb_flush = 1'b0;
        if (rst) begin
            ctrl.pc_en        = 1'b0;
            ctrl.if_id_en     = 1'b0;
            ctrl.id_ex_en     = 1'b0;
            ctrl.ex_mem_en    = 1'b0;
            ctrl.mem_wb_en    = 1'b0;
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
            ctrl.mem_wb_flush = 1'b1;
        end else if (w_freeze) begin
            // Redirect/load-use are ignored; the frozen EX/ID will re-raise them.
            ctrl.pc_en        = 1'b0;
            ctrl.if_id_en     = 1'b0;
            ctrl.id_ex_en     = 1'b0;
            ctrl.ex_mem_en    = 1'b0;
            ctrl.mem_wb_flush = 1'b1;
        end else if (w_eff_rpend) begin
            // PC already holds the target; only a new redirect may move it.
            ctrl.if_id_flush = 1'b1;
            ctrl.pc_en       = ctrl.br_redirect;
            ctrl.id_ex_flush = ctrl.br_redirect;
        end else if (ctrl.br_redirect) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else if (ctrl.hz_stall) begin
            // Holding IF/ID also covers a concurrent IMEM wait: no flush, so
            // the ID instruction is preserved.
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
        end else if (!ctrl.imem_ack) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_pend        <= 1'b0;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (w_freeze) begin
                r_state <= S_DWAIT;
                r_pend  <= w_eff_rpend;
            end else if (w_eff_rpend) begin
                r_pend  <= 1'b0;
                r_state <= (ctrl.imem_ack && !ctrl.br_redirect) ? S_RUN : S_RPEND;
            end else begin
                r_pend  <= 1'b0;
                r_state <= (ctrl.br_redirect && !ctrl.imem_ack) ? S_RPEND : S_RUN;
            end

            if ((r_state == S_DWAIT) && w_freeze) begin
                if (r_wait_cnt != C_CNT_MAX) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                if (r_wait_cnt == C_TIMEOUT) begin
                    r_mem_timeout <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign ctrl.mem_timeout = r_mem_timeout;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] r_perf_stall_cyc;
    logic [31:0] r_perf_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall_cyc <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (!ctrl.pc_en) begin
                r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
            end
            if (w_redirect) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cyc = r_perf_stall_cyc;
    assign perf_flush_cnt = r_perf_flush_cnt;
`else
    logic w_unused;
    assign w_unused = w_redirect;
`endif

endmodule
`default_nettype wire
